// File: rtl/unlock_code_serializer.sv
// unlock_code_serializer: sends a parallel code word MSB-first as serial strobes
// with a programmable idle gap between bits, feeding the serial unlock FSM.
module unlock_code_serializer #(
    parameter int CODE_WIDTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_WIDTH-1:0] code_in,
    input  logic                  code_valid,
    output logic                  code_ready,
    input  logic                  abort,
    output logic                  serial_ready,
    output logic                  serial_valid,
    output logic                  serial_data,
    output logic                  frame_done,
    output logic                  busy
);
    localparam logic [1:0] IDLE = 2'd0, BIT = 2'd1, GAP = 2'd2, DONE = 2'd3;
    localparam int CW = $clog2(CODE_WIDTH);
    localparam logic [CW-1:0] BIT_LOAD = CW'(CODE_WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    logic [1:0]            state;
    logic [CODE_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic [3:0]            gap_cnt;
    logic                  last_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (state != IDLE && abort) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (code_valid) begin
                    shreg   <= code_in;
                    bit_cnt <= BIT_LOAD;
                    state   <= BIT;
                end
                BIT: begin
                    // the shift register moves on, so remember the bit for the gap
                    last_bit <= shreg[CODE_WIDTH-1];
                    if (bit_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        shreg   <= {shreg[CODE_WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP_CYCLES > 0 ? GAP : BIT;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd0) state <= BIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign code_ready   = state == IDLE;
    assign busy         = state != IDLE;
    assign serial_ready = state == BIT || state == GAP;
    assign serial_valid = state == BIT && !abort;
    assign serial_data  = state == BIT ? shreg[CODE_WIDTH-1] : state == GAP ? last_bit : 1'b0;
    assign frame_done   = state == DONE;
endmodule

// File: tb/tb_unlock_code_serializer.sv
// tb_unlock_code_serializer: directed checks of the serializer with gap=1 and gap=0
// instances sharing one stimulus stream.
module tb_unlock_code_serializer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] code_in = 4'd0;
    logic       code_valid = 1'b0;
    logic       abort = 1'b0;
    logic       cr1, sr1, sv1, sd1, fd1, bz1;
    logic       cr0, sr0, sv0, sd0, fd0, bz0;
    logic       sel = 1'b0;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] pat;

    always #5 clk = ~clk;

    unlock_code_serializer #(.CODE_WIDTH(4), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .code_ready(cr1), .abort(abort), .serial_ready(sr1), .serial_valid(sv1),
        .serial_data(sd1), .frame_done(fd1), .busy(bz1));

    unlock_code_serializer #(.CODE_WIDTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .code_ready(cr0), .abort(abort), .serial_ready(sr0), .serial_valid(sv0),
        .serial_data(sd0), .frame_done(fd0), .busy(bz0));

    logic cr, sr, sv, sd, fd, bz;
    assign cr = sel ? cr0 : cr1;
    assign sr = sel ? sr0 : sr1;
    assign sv = sel ? sv0 : sv1;
    assign sd = sel ? sd0 : sd1;
    assign fd = sel ? fd0 : fd1;
    assign bz = sel ? bz0 : bz1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic e_cr, input logic e_sr, input logic e_sv,
                           input logic e_sd, input logic e_fd, input logic e_bz);
        chk({tag, ".code_ready"}, cr, e_cr);
        chk({tag, ".serial_ready"}, sr, e_sr);
        chk({tag, ".serial_valid"}, sv, e_sv);
        chk({tag, ".serial_data"}, sd, e_sd);
        chk({tag, ".frame_done"}, fd, e_fd);
        chk({tag, ".busy"}, bz, e_bz);
    endtask

    // Frame on the gap=1 instance: bit k in cycle 1+2k, data held in the gap,
    // frame_done in cycle 8, code_ready back in cycle 9.
    task automatic frame_g1(input string tag, input logic [3:0] code, input bit scramble);
        sel = 1'b0;
        chk({tag, ".ready_before"}, cr, 1'b1);
        code_in = code;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk_all($sformatf("%s.c%0d", tag, c), c == 9, c <= 7, c <= 7 && c % 2 == 1,
                    c <= 7 ? code[3 - (c - 1) / 2] : 1'b0, c == 8, c <= 8);
            if (scramble && c < 9) begin
                code_in = ~code_in ^ 4'(c);
                code_valid = c[0];
            end
            if (c < 9) tick();
        end
        code_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        sel = 1'b0;
        chk_all("reset_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk_all("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        frame_g1("f1011", 4'b1011, 1'b0);
        tick();
        frame_g1("f1001", 4'b1001, 1'b0);
        repeat (2) tick();

        // gap=0: word held valid, second accepted at edge 6, bits in cycles 7-10
        sel = 1'b1;
        pat = 4'b1011;
        code_in = pat;
        code_valid = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 7) code_valid = 1'b0;
            chk($sformatf("b2b.c%0d.serial_valid", c), sv, c <= 4 || c >= 7);
            chk($sformatf("b2b.c%0d.serial_data", c), sd,
                c <= 4 ? pat[4 - c] : c >= 7 ? pat[10 - c] : 1'b0);
            chk($sformatf("b2b.c%0d.frame_done", c), fd, c == 5);
            chk($sformatf("b2b.c%0d.code_ready", c), cr, c == 6);
            tick();
        end
        chk("b2b.c11.frame_done", fd, 1'b1);
        tick();
        chk("b2b.c12.code_ready", cr, 1'b1);
        repeat (3) tick();

        // abort in cycle 3 of a gap=1 frame
        sel = 1'b0;
        code_in = 4'b1011;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("abort.c1.serial_valid", sv, 1'b1);
        tick();
        chk("abort.c2.serial_valid", sv, 1'b0);
        tick();
        abort = 1'b1;
        #1;
        chk("abort.c3.serial_valid", sv, 1'b0);
        chk("abort.c3.serial_ready", sr, 1'b1);
        tick();
        abort = 1'b0;
        chk_all("abort.c4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("abort.c5.frame_done", fd, 1'b0);
        frame_g1("after_abort", 4'b1001, 1'b0);
        repeat (2) tick();

        // asynchronous reset while in a gap
        code_in = 4'b0110;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        tick();
        chk("rst_gap.pre.serial_ready", sr, 1'b1);
        chk("rst_gap.pre.serial_data", sd, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk_all("rst_gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        frame_g1("after_rst", 4'b1011, 1'b0);
        tick();

        // inputs churned while busy must not disturb the latched word
        frame_g1("scramble", 4'b1101, 1'b1);
        tick();
        chk("scramble.no_extra.busy", bz, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
